regfile_param: RTL and testbench

Parameterised multi-port register file, the next generation of the team's single-bit and 32-bit enable registers and hardwired-zero register.
- One write port, two asynchronous read ports.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Per-entry pending-write scoreboard that the CPU datapath uses for hazard detection between issue and writeback.

---
 rtl/regfile_param.sv | 99 +++++++++
 tb/tb_regfile_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, two combinational read ports,
// optional hardwired-zero entry 0, optional write-to-read bypass and a pending-write scoreboard.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reserve is applied after the clear so a same-address reserve wins over retirement.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            pend_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_word(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored
    );
        logic [WIDTH-1:0] d;
        d = stored;
        if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
            d = wr_data;
        end
        if ((ZERO_REG != 0) && (a == '0)) begin
            d = '0;
        end
        return d;
    endfunction

    // Forwarded clear only applies when no new producer reserves the same entry this cycle.
    function automatic logic read_busy(
        input logic [ADDR_W-1:0] a,
        input logic              stored
    );
        logic b;
        b = stored;
        if ((BYPASS != 0) && wr_en && (wr_addr == a) && !(rsv_en && (rsv_addr == a))) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        rd_data1 = read_word(rd_addr1, mem_q[rd_addr1]);
        rd_data2 = read_word(rd_addr2, mem_q[rd_addr2]);
        busy1    = read_busy(rd_addr1, pend_q[rd_addr1]);
        busy2    = read_busy(rd_addr2, pend_q[rd_addr2]);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build, a no-zero/no-bypass build, and an 8x4 build.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [31:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
    logic        a_busy1, a_busy2, b_busy1, b_busy2;

    logic        s_wr_en;
    logic [1:0]  s_wr_addr;
    logic [7:0]  s_wr_data;
    logic [1:0]  s_rd_addr1;
    logic [1:0]  s_rd_addr2;
    logic        s_rsv_en;
    logic [1:0]  s_rsv_addr;
    logic [7:0]  s_rd_data1, s_rd_data2;
    logic        s_busy1, s_busy2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(a_rd_data1), .rd_addr2(rd_addr2), .rd_data2(a_rd_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(a_busy1), .busy2(a_busy2)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(b_rd_data1), .rd_addr2(rd_addr2), .rd_data2(b_rd_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(b_busy1), .busy2(b_busy2)
    );

    regfile_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u_s (
        .clk(clk), .reset(reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_addr1(s_rd_addr1), .rd_data1(s_rd_data1), .rd_addr2(s_rd_addr2), .rd_data2(s_rd_data2),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .busy1(s_busy1), .busy2(s_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; rsv_en = 1'b0; rsv_addr = '0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_rd_addr1 = '0; s_rd_addr2 = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
        tick();
        rd_addr1 = 5'd5;
        #1;
        check("reset_rd1", a_rd_data1, 32'h0);
        check("reset_busy1", {31'b0, a_busy1}, 32'h0);
        reset = 1'b0;

        // write 5 and reserve it in the same cycle, then assert reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        check("wr5_rd1", a_rd_data1, 32'hDEADBEEF);
        check("rsv5_busy1", {31'b0, a_busy1}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rd1", a_rd_data1, 32'h0);
        check("async_rst_busy1", {31'b0, a_busy1}, 32'h0);
        #1 reset = 1'b0;

        // two writes, then both ports
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        wr_addr = 5'd31; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd31;
        #1;
        check("rd7_p1", a_rd_data1, 32'h12345678);
        check("rd31_p2", a_rd_data2, 32'hFFFFFFFF);
        check("b_rd7_p1", b_rd_data1, 32'h12345678);
        rd_addr2 = 5'd7;
        #1;
        check("same_addr_p2", a_rd_data2, 32'h12345678);

        // zero register
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hA5A5A5A5;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        #1;
        check("zero_no_bypass", a_rd_data1, 32'h0);
        tick();
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0;
        #1;
        check("zero_rd1", a_rd_data1, 32'h0);
        check("zero_rd2", a_rd_data2, 32'h0);
        check("zero_busy1", {31'b0, a_busy1}, 32'h0);
        check("nz_rd1", b_rd_data1, 32'hA5A5A5A5);
        check("nz_rd2", b_rd_data2, 32'hA5A5A5A5);
        check("nz_busy1", {31'b0, b_busy1}, 32'h1);

        // bypass versus registered read
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        tick();
        wr_data = 32'h22; rd_addr1 = 5'd3;
        #1;
        check("bypass_on", a_rd_data1, 32'h22);
        check("bypass_off_pre", b_rd_data1, 32'h11);
        tick();
        wr_en = 1'b0;
        #1;
        check("bypass_off_post", b_rd_data1, 32'h22);

        // scoreboard
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0; rd_addr1 = 5'd9;
        #1;
        check("sb_rsv9", {31'b0, a_busy1}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        check("sb_wr9_bypass", {31'b0, a_busy1}, 32'h0);
        check("sb_wr9_nobypass", {31'b0, b_busy1}, 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        check("sb_wr9_post", {31'b0, a_busy1}, 32'h0);
        check("b_sb_wr9_post", {31'b0, b_busy1}, 32'h0);
        wr_en = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        check("sb_both9_pre", {31'b0, a_busy1}, 32'h0);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        check("sb_both9_post", {31'b0, a_busy1}, 32'h1);
        check("b_sb_both9_post", {31'b0, b_busy1}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd9; rsv_en = 1'b1; rsv_addr = 5'd10;
        rd_addr2 = 5'd10;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        check("sb_diff_clr9", {31'b0, a_busy1}, 32'h0);
        check("sb_diff_set10", {31'b0, a_busy2}, 32'h1);

        // 8-bit x 4 build
        s_wr_en = 1'b1; s_wr_data = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            s_wr_addr = 2'(i);
            tick();
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_rd_addr1 = 2'(i);
            s_rd_addr2 = 2'(3 - i);
            #1;
            check($sformatf("small_p1_%0d", i), {24'b0, s_rd_data1}, (i == 0) ? 32'h0 : 32'hC3);
            check($sformatf("small_p2_%0d", i), {24'b0, s_rd_data2}, (i == 3) ? 32'h0 : 32'hC3);
        end
        s_rsv_en = 1'b1; s_rsv_addr = 2'd2;
        tick();
        s_rsv_en = 1'b0; s_rd_addr1 = 2'd2;
        #1;
        check("small_busy2", {31'b0, s_busy1}, 32'h1);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rd_addr1 = 2'(i);
            #1;
            check($sformatf("small_rst_%0d", i), {24'b0, s_rd_data1}, 32'h0);
            check($sformatf("small_rst_busy_%0d", i), {31'b0, s_busy1}, 32'h0);
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
